// File: rtl/tinyalu_pkg.sv
// Shared TinyALU definitions: operand/result widths, opcode encodings, FSM states.
// ILLEGAL_RESULT is driven only in builds with TINYALU_ILLEGAL_OP_EN defined.
package tinyalu_pkg;

    localparam int OP_W  = 8;
    localparam int RES_W = 2 * OP_W;

    localparam logic [RES_W-1:0] ILLEGAL_RESULT = 16'hDEAD;

    typedef enum logic [2:0] {
        NO_OP  = 3'b000,
        ADD_OP = 3'b001,
        AND_OP = 3'b010,
        XOR_OP = 3'b011,
        MUL_OP = 3'b100
    } operation_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

endpackage

// File: rtl/tinyalu_if.sv
// TinyALU command/response bundle between the driver (master) and the core (slave).
// Handshake: master raises start with stable op/A/B and holds start until it sees done;
// slave accepts on the first posedge it is idle with start high, then pulses done for
// exactly one cycle with result valid. done is never high two cycles in a row.
interface tinyalu_if;
    import tinyalu_pkg::*;

    logic [OP_W-1:0]  A;
    logic [OP_W-1:0]  B;
    logic [2:0]       op;
    logic             start;
    logic             done;
    logic [RES_W-1:0] result;
    logic             err;

    modport master (
        output A, B, op, start,
        input  done, result, err
    );

    modport slave (
        input  A, B, op, start,
        output done, result, err
    );

endinterface

// File: rtl/tinyalu_mul_pipe.sv
// MUL_LAT-stage registered unsigned multiplier: the product is formed on the launch
// edge and then shifted down a register chain alongside an async-cleared valid bit.
module tinyalu_mul_pipe
    import tinyalu_pkg::*;
#(
    parameter int MUL_LAT = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_start,
    input  logic [OP_W-1:0]  i_a,
    input  logic [OP_W-1:0]  i_b,
    output logic             o_vld,
    output logic [RES_W-1:0] o_prod
);

    logic [MUL_LAT-1:0] r_vld;
    logic [RES_W-1:0]   r_prod [MUL_LAT];
    logic [RES_W-1:0]   w_prod;

    assign w_prod = {{OP_W{1'b0}}, i_a} * {{OP_W{1'b0}}, i_b};

    // Only the valid chain needs reset; a reset mid-flight must never surface a result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld <= '0;
        end else begin
            r_vld <= {r_vld[MUL_LAT-2:0], i_start};
        end
    end

    always_ff @(posedge clk) begin
        if (i_start) begin
            r_prod[0] <= w_prod;
        end
        for (int i = 1; i < MUL_LAT; i++) begin
            r_prod[i] <= r_prod[i-1];
        end
    end

    assign o_vld  = r_vld[MUL_LAT-1];
    assign o_prod = r_prod[MUL_LAT-1];

endmodule

// File: rtl/tinyalu_core.sv
// TinyALU core: add/and/xor complete on the acceptance edge, mul via tinyalu_mul_pipe.
// Build macro TINYALU_ILLEGAL_OP_EN: illegal opcodes answer done+err with 16'hDEAD.
module tinyalu_core
    import tinyalu_pkg::*;
#(
    parameter int MUL_LAT = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    tinyalu_if.slave   bus,
    output state_t     o_state
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic [RES_W-1:0] r_result;
    logic [RES_W-1:0] w_result_nxt;
    logic             w_err_nxt;
    logic             w_mul_start;
    logic             w_mul_vld;
    logic [RES_W-1:0] w_mul_prod;
    logic [OP_W:0]    w_sum;

    assign w_sum = {1'b0, bus.A} + {1'b0, bus.B};

    tinyalu_mul_pipe #(
        .MUL_LAT (MUL_LAT)
    ) u_mul_pipe (
        .clk     (clk),
        .reset_n (reset_n),
        .i_start (w_mul_start),
        .i_a     (bus.A),
        .i_b     (bus.B),
        .o_vld   (w_mul_vld),
        .o_prod  (w_mul_prod)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_done_nxt   = 1'b0;
        w_err_nxt    = 1'b0;
        w_result_nxt = r_result;
        w_mul_start  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        ADD_OP: begin
                            w_done_nxt   = 1'b1;
                            w_result_nxt = {{(RES_W-OP_W-1){1'b0}}, w_sum};
                            w_state_nxt  = WAIT_LOW;
                        end
                        AND_OP: begin
                            w_done_nxt   = 1'b1;
                            w_result_nxt = {{OP_W{1'b0}}, bus.A & bus.B};
                            w_state_nxt  = WAIT_LOW;
                        end
                        XOR_OP: begin
                            w_done_nxt   = 1'b1;
                            w_result_nxt = {{OP_W{1'b0}}, bus.A ^ bus.B};
                            w_state_nxt  = WAIT_LOW;
                        end
                        MUL_OP: begin
                            w_mul_start = 1'b1;
                            w_state_nxt = MUL_BUSY;
                        end
                        NO_OP: begin
                        end
                        default: begin
`ifdef TINYALU_ILLEGAL_OP_EN
                            w_done_nxt   = 1'b1;
                            w_err_nxt    = 1'b1;
                            w_result_nxt = ILLEGAL_RESULT;
                            w_state_nxt  = WAIT_LOW;
`endif
                        end
                    endcase
                end
            end
            MUL_BUSY: begin
                // The driver may already have let go of start; skip WAIT_LOW then.
                if (w_mul_vld) begin
                    w_done_nxt   = 1'b1;
                    w_result_nxt = w_mul_prod;
                    w_state_nxt  = bus.start ? WAIT_LOW : IDLE;
                end
            end
            WAIT_LOW: begin
                if (!bus.start) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done   <= w_done_nxt;
            r_result <= w_result_nxt;
        end
    end

`ifdef TINYALU_ILLEGAL_OP_EN
    logic r_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err_nxt;
        end
    end

    assign bus.err = r_err;
`else
    assign bus.err = w_err_nxt;
`endif

    assign bus.done   = r_done;
    assign bus.result = r_result;
    assign o_state    = r_state;

endmodule

// File: tb/tb_tinyalu_core.sv
// Directed bench for tinyalu_core: expected results queued at issue, checked by a
// done-triggered monitor. Honours TINYALU_ILLEGAL_OP_EN the same way the design does.
module tb_tinyalu_core;
    import tinyalu_pkg::*;

    localparam int MUL_LAT = 3;

    logic   clk;
    logic   reset_n;
    state_t o_state;

    tinyalu_if bus();

    tinyalu_core #(
        .MUL_LAT (MUL_LAT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave),
        .o_state (o_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int               n_checks = 0;
    int               n_fail   = 0;
    logic [RES_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // scoreboard monitor
    initial begin
        logic             prev_done;
        logic [RES_W-1:0] e;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.done) begin
                check("done_not_back_to_back", {31'b0, prev_done}, 32'd0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: result %0h with no command pending (t=%0t)",
                             bus.result, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("result", {16'b0, bus.result}, {16'b0, e});
                end
            end
            prev_done = bus.done;
        end
    end

    // driver: issue one command, wait for done, hold start for `hold` more cycles, release
    task automatic run_cmd(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                           input logic [15:0] exp, input logic exp_err,
                           input int lat, input int hold);
        int n;
        @(negedge clk);
        bus.op    = o;
        bus.A     = a;
        bus.B     = b;
        bus.start = 1'b1;
        exp_q.push_back(exp);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            bus.A = 8'h00;
            bus.B = 8'h00;
        end while (!bus.done && n < 20);
        check("done_latency", n, lat + 1);
        check("err_at_done", {31'b0, bus.err}, {31'b0, exp_err});
        check("state_after_done", {30'b0, o_state}, {30'b0, WAIT_LOW});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("done_low_while_held", {31'b0, bus.done}, 32'd0);
        end
        bus.start = 1'b0;
        @(negedge clk);
        check("idle_after_release", {30'b0, o_state}, {30'b0, IDLE});
    endtask

    // stimulus
    initial begin
        int n;
        reset_n   = 1'b0;
        bus.A     = 8'h00;
        bus.B     = 8'h00;
        bus.op    = 3'b000;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_done",   {31'b0, bus.done}, 32'd0);
        check("reset_result", {16'b0, bus.result}, 32'd0);
        check("reset_err",    {31'b0, bus.err}, 32'd0);
        check("reset_state",  {30'b0, o_state}, {30'b0, IDLE});
        reset_n = 1'b1;
        @(negedge clk);

        run_cmd(ADD_OP, 8'hFF, 8'h01, 16'h0100, 1'b0, 0, 2);
        run_cmd(MUL_OP, 8'hFF, 8'hFF, 16'hFE01, 1'b0, MUL_LAT, 1);
        run_cmd(XOR_OP, 8'hF0, 8'hAA, 16'h005A, 1'b0, 0, 5);

        // no_op held for several cycles: nothing happens, then and is taken
        @(negedge clk);
        bus.op = NO_OP; bus.A = 8'h12; bus.B = 8'h34; bus.start = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("noop_state",  {30'b0, o_state}, {30'b0, IDLE});
            check("noop_result", {16'b0, bus.result}, 32'h005A);
        end
        run_cmd(AND_OP, 8'h0F, 8'h3C, 16'h000C, 1'b0, 0, 1);

        run_cmd(MUL_OP, 8'h12, 8'h34, 16'h03A8, 1'b0, MUL_LAT, 0);

        // start dropped while the mul is in flight
        @(negedge clk);
        bus.op = MUL_OP; bus.A = 8'h0A; bus.B = 8'h0B; bus.start = 1'b1;
        exp_q.push_back(16'h006E);
        @(negedge clk);
        bus.start = 1'b0;
        n = 1;
        while (!bus.done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("early_drop_latency", n, MUL_LAT + 1);
        check("early_drop_state", {30'b0, o_state}, {30'b0, IDLE});

        run_cmd(ADD_OP, 8'h80, 8'h7F, 16'h00FF, 1'b0, 0, 1);

`ifdef TINYALU_ILLEGAL_OP_EN
        run_cmd(3'b110, 8'h55, 8'h66, 16'hDEAD, 1'b1, 0, 1);
`else
        @(negedge clk);
        bus.op = 3'b110; bus.A = 8'h55; bus.B = 8'h66; bus.start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("illegal_err",   {31'b0, bus.err}, 32'd0);
            check("illegal_state", {30'b0, o_state}, {30'b0, IDLE});
        end
        bus.start = 1'b0;
`endif

        // asynchronous reset one cycle into a mul
        @(negedge clk);
        bus.op = MUL_OP; bus.A = 8'hC3; bus.B = 8'h5A; bus.start = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset_n   = 1'b0;
        bus.start = 1'b0;
        #1;
        check("async_reset_result", {16'b0, bus.result}, 32'd0);
        check("async_reset_state",  {30'b0, o_state}, {30'b0, IDLE});
        @(negedge clk);
        reset_n = 1'b1;
        repeat (MUL_LAT + 2) begin
            @(negedge clk);
            check("aborted_mul_done",   {31'b0, bus.done}, 32'd0);
            check("aborted_mul_result", {16'b0, bus.result}, 32'd0);
        end
        run_cmd(ADD_OP, 8'h02, 8'h03, 16'h0005, 1'b0, 0, 1);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached at t=%0t", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
